sistema_mem_arbiter: RTL and testbench
======================================

// Module: sistema_mem_arbiter
// PURPOSE
//  Shares the single-port on-chip data RAM (16K x 32, byte-enabled, 1-cycle read latency) between two
//  Avalon-MM masters: m0 = NIOS data master, m1 = accumulator DMA. Round-robin, one access per cycle,
//  fully pipelined reads. Sits between the interconnect and the RAM's s1 port.
// PARAMETERS
//  ADDR_W       14            word address width (DEPTH = 2**ADDR_W)
//  DATA_W       32            data width
//  BE_W         4             byteenable width (DATA_W/8)
//  CLEAR_VALUE  32'h0000_0000 word written by the clear engine (only with SISTEMA_MEM_CLEAR_EN)
// PORTS
//  clk              in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  m0_address       in   ADDR_W  master 0 word address
//  m0_byteenable    in   BE_W    master 0 byte lanes
//  m0_read          in   1       master 0 read request
//  m0_write         in   1       master 0 write request
//  m0_writedata     in   DATA_W  master 0 write data
//  m0_waitrequest   out  1       1 = m0 request not accepted this cycle
//  m0_readdata      out  DATA_W  m0 read data, qualified by m0_readdatavalid
//  m0_readdatavalid out  1       one-cycle pulse, m0 read data valid
//  m1_*             --   --      identical set for master 1
//  mem_address      out  ADDR_W  RAM address
//  mem_byteenable   out  BE_W    RAM byte enables
//  mem_chipselect   out  1       RAM select
//  mem_write        out  1       RAM write enable (qualified by chipselect)
//  mem_writedata    out  DATA_W  RAM write data
//  mem_clken        out  1       RAM clock enable
//  mem_readdata     in   DATA_W  RAM q (valid the cycle after a read is issued)
//  clear_busy       out  1       1 while the clear engine owns the RAM
// BEHAVIOUR
//  - Reset values: m*_waitrequest=1, m*_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0,
//    clear_busy=0, rr pointer=1 (m0 wins the first contention), rd pipe tags cleared.
//  - First edge after reset release: mem_clken=1 from then on; FSM leaves ST_RESET.
//  - FSM: ST_RESET -> ST_CLEAR (macro on) or ST_RUN (macro off); ST_CLEAR -> ST_RUN after last word.
//  - ST_RUN request = read|write. If read and write are both high, write wins; no error is flagged.
//    Only m0 requests: grant m0. Only m1 requests: grant m1.
//    Both request: grant !last; last <= granted master.
//  - Grant is combinational in the same cycle: granted master gets waitrequest=0, the other gets 1.
//    Idle masters see waitrequest=1.
//    Granted master's address/byteenable/writedata drive mem_*; mem_chipselect=1; mem_write=its write.
//  - Read issued in cycle N: registered tag {valid,id} -> in N+1 mX_readdatavalid=1 for id X.
//    mX_readdata = mem_readdata. Non-selected master's readdata holds its last value.
//  - Back-to-back reads (any master mix) sustain 1/cycle; response order = issue order.
//  - Write latency 0: accepted in the grant cycle; no response.
//  - Write in N and read of the same address in N+1 returns the new data.
//  - Async reset mid-operation: in-flight read tag discarded, no readdatavalid, clear restarts from 0.
// CONFIGURATION
//  SISTEMA_MEM_CLEAR_EN defined: ST_CLEAR walks addresses 0..DEPTH-1, one write/cycle, CLEAR_VALUE.
//    byteenable all 1s; clear_busy=1; both waitrequests=1.
//    Takes DEPTH cycles (16384 at default), then ST_RUN.
//  Not defined: no clear counter; clear_busy tied 0; ST_RESET -> ST_RUN directly.
// STRUCTURE
//  Package sistema_mem_arb_pkg: state enum {ST_RESET, ST_CLEAR, ST_RUN}; master id constants
//    M0=1'b0, M1=1'b1; default ADDR_W/DATA_W/BE_W.
//  Sub-module sistema_rr_arb2: 2-way round-robin grant (req[1:0], last -> gnt[1:0], gnt_id); pure comb.
//  Top holds FSM, last-grant reg, read tag pipe, clear counter, mem mux.
// TESTING
//  1 m0 write 0x10=0xDEADBEEF be=4'hF, then m0 read 0x10 -> waitrequest 0 both cycles,
//    m0_readdatavalid pulse one cycle after read with data 0xDEADBEEF.
//  2 m0 and m1 read every cycle for 8 cycles -> grants alternate m0,m1,m0...; m0 wins cycle 1;
//    each readdatavalid pulses only for its owner, 1 cycle after issue.
//  3 Write 0x20=0x11223344, then m1 write 0x20=0xAABBCCDD be=4'b0101, then read
//    -> 0x11BB33DD.
//  4 Assert reset in the cycle after a read is issued -> no readdatavalid; after release,
//    waitrequest=1 for 1 cycle (macro off), then normal service.
//  5 SISTEMA_MEM_CLEAR_EN, ADDR_W=4: after reset, clear_busy=1 for 16 cycles, requests stalled;
//    then read any address -> CLEAR_VALUE.
//  6 m0 read and write both high on 0x05 -> write performed, no readdatavalid.

Source files
------------

// File: rtl/sistema_mem_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Contents: FSM state enum, master id constants, default bus widths, read tag payload.
package sistema_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_BE_W   = 4;

  // One entry of the read-return pipe: which master owns next cycle's RAM q.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/sistema_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the data RAM.
// Signals: address, byteenable, read, write, writedata (request),
//          waitrequest, readdata, readdatavalid (response).
// Modports: master (the requester), slave (the arbiter side).
interface sistema_mem_arbiter_if
  import sistema_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BE_W   = DEF_BE_W
) ();

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sistema_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: i_req[1:0] request vector, i_last id of the previous winner,
//        o_gnt[1:0] one-hot grant (zero when idle), o_gnt_id id of the winner.
module sistema_rr_arb2
  import sistema_mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt_id = M0;
    if (i_req == 2'b11) begin
      o_gnt_id = ~i_last;
    end else if (i_req[1]) begin
      o_gnt_id = M1;
    end
    if (i_req != 2'b00) begin
      o_gnt = (o_gnt_id == M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sistema_mem_arbiter.sv
// Shares the single-port 1-cycle-latency data RAM between two Avalon-MM masters
// (m0 = NIOS data master, m1 = accumulator DMA). Round-robin, one access per cycle,
// fully pipelined reads returned in issue order.
// Ports: clk, reset (async, active high); m0/m1 slave modports; mem_* RAM s1 side;
//        clear_busy high while the clear engine owns the RAM.
// Build option: SISTEMA_MEM_CLEAR_EN adds a post-reset clear of every word to CLEAR_VALUE.
module sistema_mem_arbiter
  import sistema_mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       BE_W        = DEF_BE_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  sistema_mem_arbiter_if.slave m0,
  sistema_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              clear_busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_clken;
  logic              r_last;
  rd_tag_t           r_tag;
  rd_tag_t           w_tag_nxt;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_gnt_id;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wd;

`ifdef SISTEMA_MEM_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_last;
  assign w_clr_last = (r_clr_cnt == '1);
`endif

  // Requests only count in ST_RUN; elsewhere nobody is granted.
  assign w_req = (r_state == ST_RUN) ?
                 {m1.read | m1.write, m0.read | m0.write} : 2'b00;

  sistema_rr_arb2 u_rr (
    .i_req    (w_req),
    .i_last   (r_last),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  // Winner's request fields.
  assign w_sel_rd   = (w_gnt_id == M1) ? m1.read       : m0.read;
  assign w_sel_wr   = (w_gnt_id == M1) ? m1.write      : m0.write;
  assign w_sel_addr = (w_gnt_id == M1) ? m1.address    : m0.address;
  assign w_sel_be   = (w_gnt_id == M1) ? m1.byteenable : m0.byteenable;
  assign w_sel_wd   = (w_gnt_id == M1) ? m1.writedata  : m0.writedata;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef SISTEMA_MEM_CLEAR_EN
      ST_RESET: w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
`else
      ST_RESET: w_state_nxt = ST_RUN;
      ST_CLEAR: w_state_nxt = ST_RUN;
`endif
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  // RAM port mux and read tag; a simultaneous read+write is treated as a write only.
  // The idle write-data bus parks on the clear word.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = CLEAR_VALUE;
    w_tag_nxt      = '0;
    if (w_gnt != 2'b00) begin
      mem_address     = w_sel_addr;
      mem_byteenable  = w_sel_be;
      mem_chipselect  = 1'b1;
      mem_write       = w_sel_wr;
      mem_writedata   = w_sel_wd;
      w_tag_nxt.valid = w_sel_rd & ~w_sel_wr;
      w_tag_nxt.id    = w_gnt_id;
    end
`ifdef SISTEMA_MEM_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      mem_address    = r_clr_cnt;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_writedata  = CLEAR_VALUE;
    end
`endif
  end

  // State, clock enable, round-robin history, read-return pipe and readdata holders.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_clken <= 1'b0;
      r_last  <= M1;
      r_tag   <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_clken <= 1'b1;
      if (w_gnt != 2'b00) r_last <= w_gnt_id;
      r_tag   <= w_tag_nxt;
      if (r_tag.valid && (r_tag.id == M0)) r_rd0 <= mem_readdata;
      if (r_tag.valid && (r_tag.id == M1)) r_rd1 <= mem_readdata;
    end
  end

`ifdef SISTEMA_MEM_CLEAR_EN
  // Clear address walker; restarts from word 0 on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end
  assign clear_busy = (r_state == ST_CLEAR);
`else
  assign clear_busy = 1'b0;
`endif

  assign mem_clken = r_clken;

  assign m0.waitrequest = ~w_gnt[0];
  assign m1.waitrequest = ~w_gnt[1];

  // RAM q goes straight to its owner; the other master keeps its last returned word.
  assign m0.readdatavalid = r_tag.valid && (r_tag.id == M0);
  assign m1.readdatavalid = r_tag.valid && (r_tag.id == M1);
  assign m0.readdata      = m0.readdatavalid ? mem_readdata : r_rd0;
  assign m1.readdata      = m1.readdatavalid ? mem_readdata : r_rd1;

endmodule

// File: tb/tb_sistema_mem_arbiter.sv
// Directed bench for sistema_mem_arbiter with a behavioural RAM, a reference memory
// and a scoreboard queue of expected read returns.
module tb_sistema_mem_arbiter;
  import sistema_mem_arb_pkg::*;

`ifdef SISTEMA_MEM_CLEAR_EN
  localparam int unsigned AW = 4;
`else
  localparam int unsigned AW = 14;
`endif
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] CLR   = 32'hC1EA_5A5A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sistema_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
  sistema_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;
  logic          clear_busy;

  sistema_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CLEAR_VALUE(CLR)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .clear_busy     (clear_busy)
  );

  // Synchronous single-port RAM, byte-enabled, q valid the cycle after a read.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  logic        ref_last;
  logic [31:0] last_rd0, last_rd1;
  bit          running, clearing;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
    m0_if.byteenable = '0; m0_if.writedata = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
    m1_if.byteenable = '0; m1_if.writedata = '0;
  endtask

  task automatic drive(input logic id, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (id == M0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = wd;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = wd;
    end
  endtask

  // One clock: check grants/responses at negedge, update model, advance past posedge.
  task automatic step(input string tag);
    logic [1:0]    req, ew;
    logic          gv, gid, rd, wr;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
    exp_t          e;
    @(negedge clk);
    req = {m1_if.read | m1_if.write, m0_if.read | m0_if.write};
    gv  = running && (req != 2'b00);
    gid = (req == 2'b11) ? ~ref_last : req[1];
    ew  = 2'b11;
    if (gv) ew[gid] = 1'b0;
    chk({tag, " wait"}, 32'({m1_if.waitrequest, m0_if.waitrequest}), 32'(ew));
    chk({tag, " busy"}, 32'(clear_busy), 32'(clearing));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " rvalid"}, 32'({m1_if.readdatavalid, m0_if.readdatavalid}),
          (e.id == M1) ? 32'd2 : 32'd1);
      if (e.id == M1) begin
        chk({tag, " rdata1"}, m1_if.readdata, e.data);
        chk({tag, " hold0"}, m0_if.readdata, last_rd0);
        last_rd1 = e.data;
      end else begin
        chk({tag, " rdata0"}, m0_if.readdata, e.data);
        chk({tag, " hold1"}, m1_if.readdata, last_rd1);
        last_rd0 = e.data;
      end
    end else begin
      chk({tag, " rvalid"}, 32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0);
    end
    if (gv) begin
      rd = (gid == M1) ? m1_if.read       : m0_if.read;
      wr = (gid == M1) ? m1_if.write      : m0_if.write;
      a  = (gid == M1) ? m1_if.address    : m0_if.address;
      be = (gid == M1) ? m1_if.byteenable : m0_if.byteenable;
      wd = (gid == M1) ? m1_if.writedata  : m0_if.writedata;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else if (rd) begin
        sb.push_back('{id: gid, data: ref_mem[a]});
      end
      ref_last = gid;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset now, check reset values, release, and follow the start-up sequence.
  task automatic do_reset();
    reset = 1'b1;
    idle();
    sb.delete();
    ref_last = M1; last_rd0 = '0; last_rd1 = '0;
    running = 1'b0; clearing = 1'b0;
    @(negedge clk);
    chk("rst wait", 32'({m1_if.waitrequest, m0_if.waitrequest}), 32'd3);
    chk("rst rvalid", 32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0);
    chk("rst cs_wr", 32'({mem_chipselect, mem_write}), 32'd0);
    chk("rst clken", 32'(mem_clken), 32'd0);
    chk("rst busy", 32'(clear_busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(M0, 1'b1, 1'b0, AW'(3), 4'hF, 32'h0);
    step("rst exit");
    chk("clken on", 32'(mem_clken), 32'd1);
`ifdef SISTEMA_MEM_CLEAR_EN
    clearing = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) step("clear");
    clearing = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = CLR;
`endif
    running = 1'b1;
    idle();
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    idle();
    #1;
    do_reset();

    // Write then read back on m0.
    drive(M0, 1'b0, 1'b1, AW'(16), 4'hF, 32'hDEAD_BEEF); step("t1 wr");
    drive(M0, 1'b1, 1'b0, AW'(16), 4'hF, 32'h0);        step("t1 rd");
    idle();                                               step("t1 rsp");

    // Partial overwrite by m1 through byte lanes 0 and 2.
    drive(M0, 1'b0, 1'b1, AW'(32), 4'hF, 32'h1122_3344); step("t3 wr0");
    idle();
    drive(M1, 1'b0, 1'b1, AW'(32), 4'b0101, 32'hAABB_CCDD); step("t3 wr1");
    idle();
    drive(M0, 1'b1, 1'b0, AW'(32), 4'hF, 32'h0);        step("t3 rd");
    idle();                                               step("t3 rsp");

    // Read and write together: write wins, no response.
    drive(M0, 1'b1, 1'b1, AW'(5), 4'hF, 32'h5A5A_0005);  step("t6 rw");
    drive(M0, 1'b1, 1'b0, AW'(5), 4'hF, 32'h0);          step("t6 rd");
    idle();                                               step("t6 rsp");

    // Fill two regions from m1 for the contention run.
    for (int k = 0; k < 8; k++) begin
      idle();
      drive(M1, 1'b0, 1'b1, AW'(64 + k), 4'hF, 32'h4000_0000 + 32'(k * 257)); step("fill a");
      drive(M1, 1'b0, 1'b1, AW'(128 + k), 4'hF, 32'h8000_0000 + 32'(k * 4099)); step("fill b");
    end

    // Reset right after a read is issued: the return must be dropped.
    idle();
    drive(M1, 1'b1, 1'b0, AW'(16), 4'hF, 32'h0);         step("t4 rd");
    do_reset();

    // Both masters read every cycle; m0 wins first after reset.
    for (int k = 0; k < 8; k++) begin
      drive(M0, 1'b1, 1'b0, AW'(64 + k), 4'hF, 32'h0);
      drive(M1, 1'b1, 1'b0, AW'(128 + k), 4'hF, 32'h0);
      step("t2");
    end
    idle();                                               step("t2 drain");

    // Normal service after the reset.
    drive(M0, 1'b1, 1'b0, AW'(16), 4'hF, 32'h0);         step("post rd0");
    idle();
    drive(M1, 1'b1, 1'b0, AW'(32), 4'hF, 32'h0);         step("post rd1");
    idle();                                               step("post rsp");
    step("post idle");

    chk("sb empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
